fir_frame_buffer: RTL and testbench
===================================

Name: fir_frame_buffer

Overview:
Sink for the FIR output stream (fir_valid/fir_d). It collects consecutive filtered samples into N-sample frames and hands complete frames to the FFT stage over a valid/ready handshake. It uses ping-pong (two-bank) buffering, so the FIR can keep streaming while the FFT holds a frame. It sits between the FIR and the FFT in the frequency analysis path.

Parameters:
DW, 16, sample width (signed, same format as fir_d)
N, 16, samples per frame (power of 2, >= 2)
CW, 8, width of frame counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
fir_valid  input  1  fir_d holds a valid sample this cycle (one sample per cycle while high)
fir_d  input  DW  filtered sample, signed
frame_valid  output  1  a complete frame is presented on frame_data
frame_ready  input  1  FFT accepts the frame this cycle when frame_valid also high
frame_data  output  N*DW  frame; sample k (k-th received) at bits [k*DW+DW-1 : k*DW]
frame_cnt  output  CW  number of frames handed off, wraps modulo 2^CW
overflow  output  1  sticky; a sample was dropped because both banks were full

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high. When rst=1 at an edge, all state clears regardless of other inputs:
  - both banks' storage = 0; full[1:0] = 0; wr_bank = 0; rd_bank = 0; wcnt = 0
  - outputs: frame_valid = 0, frame_data = 0, frame_cnt = 0, overflow = 0
  - A partially collected frame is discarded; reset mid-frame restarts collection at sample 0 of bank 0.
- Storage: two banks of N x DW registers. wr_bank selects the bank being filled; rd_bank selects the bank presented.
- Write, at an edge with fir_valid=1:
  - If full[wr_bank]=0: bank[wr_bank][wcnt] <= fir_d.
    - If wcnt != N-1: wcnt <= wcnt+1.
    - If wcnt == N-1: wcnt <= 0, full[wr_bank] <= 1, wr_bank toggles.
  - If full[wr_bank]=1 (both banks full): sample dropped, overflow <= 1 (sticky until rst), wcnt unchanged.
    - Drops only occur at wcnt=0, so frame alignment is preserved; the next accepted sample becomes sample 0.
- fir_valid=0: nothing written; wcnt and the partial frame are held, and collection resumes when fir_valid returns. Gaps are allowed anywhere.
- Read:
  - frame_valid = full[rd_bank] (registered state, no combinational path from inputs).
  - frame_data = bank[rd_bank], driven straight from storage.
  - At an edge with frame_valid=1 and frame_ready=1: full[rd_bank] <= 0, rd_bank toggles, frame_cnt <= frame_cnt+1 (wraps 2^CW-1 -> 0).
  - frame_ready while frame_valid=0 is ignored.
- Handshake rules: once frame_valid rises, frame_valid and frame_data stay stable until accepted. Writes never target rd_bank while it is full.
- Latency: the edge that accepts sample N-1 sets full. frame_valid is high in the next cycle; with frame_ready held high, it is accepted at the following edge. Minimum time from last sample to handoff is 1 cycle.
- Simultaneous events:
  - Frame completion into bank A and acceptance of bank B at the same edge: both take effect. frame_valid stays 1 (bank A is now presented); frame_cnt increments once.
  - Acceptance while both banks are full and fir_valid=1 at wcnt=0: the write still sees full[wr_bank]=1 at that edge, so the sample is dropped and overflow is set. Full-state update takes effect next cycle; no same-cycle bypass.
- Throughput: with frame_ready tied high, the FIR streams continuously without loss. Each frame is presented for exactly 1 cycle, at most once every N cycles.
- Arithmetic: data is stored bit-exact, with no rounding or sign manipulation. wcnt is log2(N) bits.

Test Plan:
1. Reset, then fir_valid=1 for 16 cycles with fir_d = 0x0001..0x0010 and frame_ready=0 -> frame_valid=1 the cycle after the 16th sample; frame_data[15:0]=0x0001, frame_data[255:240]=0x0010; frame_cnt=0; overflow=0.
2. Continue 16 more samples 0x0011..0x0020 with frame_ready=0, then assert frame_ready for 2 cycles -> first handoff shows 0x0001..0x0010, second shows 0x0011..0x0020; frame_cnt 0->1->2; frame_valid=0 after.
3. Both banks full, frame_ready=0, fir_valid=1 with fir_d=0x7FFF for 3 cycles, then release frame_ready -> overflow=1 and stays 1; presented frames unchanged; next frame starts with the first sample accepted after a bank frees.
4. fir_valid toggling 1/0 each cycle with signed samples -8..7 (0xFFF8..0x0007), frame_ready=1 -> one frame after 16 accepted samples, exactly those values in order; overflow=0.
5. rst asserted after 9 samples of a frame, then 16 new samples 0x0100..0x010F -> first frame is exactly 0x0100..0x010F; frame_cnt=0 before handoff.
6. frame_ready=1 and continuous fir_valid for 300 frames -> no overflow, frame_valid a 1-cycle pulse every 16 cycles, frame_cnt wraps 255->0 (CW=8).

Source files
------------

// File: rtl/fir_frame_buffer_if.sv
// ============================================================================
// fir_frame_buffer_if : FIR sample stream in, frame handoff out
// Rev 1.0
// ============================================================================
`default_nettype none

interface fir_frame_buffer_if #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int CW = 8
);
  logic            fir_valid;
  logic [DW-1:0]   fir_d;
  logic            frame_valid;
  logic            frame_ready;
  logic [N*DW-1:0] frame_data;
  logic [CW-1:0]   frame_cnt;
  logic            overflow;

  modport master (
    output fir_valid, fir_d, frame_ready,
    input  frame_valid, frame_data, frame_cnt, overflow
  );

  modport slave (
    input  fir_valid, fir_d, frame_ready,
    output frame_valid, frame_data, frame_cnt, overflow
  );
endinterface

`default_nettype wire

// File: rtl/fir_frame_buffer.sv
// ============================================================================
// fir_frame_buffer : ping-pong N-sample frame collector between FIR and FFT
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_frame_buffer #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int CW = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fir_frame_buffer_if.slave bus
);

  localparam int             WW   = $clog2(N);
  localparam logic [WW-1:0]  LAST = WW'(N - 1);

  logic [N*DW-1:0] bank [2];
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wr_bank;
  logic            rd_bank;
  logic [WW-1:0]   wcnt;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic            accept;
  logic            wr_en;
  logic            wr_last;
  logic            drop;

  // full[wr_bank] can only be set while rd_bank is also full, so a drop means both banks hold frames
  always_comb begin
    accept   = full[rd_bank] & bus.frame_ready;
    wr_en    = bus.fir_valid & ~full[wr_bank];
    drop     = bus.fir_valid &  full[wr_bank];
    wr_last  = wr_en & (wcnt == LAST);
    full_nxt = full;
    if (accept)  full_nxt[rd_bank] = 1'b0;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        bank[wr_bank][int'(wcnt)*DW +: DW] <= bus.fir_d;
        if (wr_last) begin
          wcnt    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (drop) ovf <= 1'b1;
      if (accept) begin
        rd_bank <= ~rd_bank;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  assign bus.frame_valid = full[rd_bank];
  assign bus.frame_data  = bank[rd_bank];
  assign bus.frame_cnt   = cnt;
  assign bus.overflow    = ovf;

endmodule

`default_nettype wire

// File: tb/tb_fir_frame_buffer.sv
// ============================================================================
// tb_fir_frame_buffer : directed vectors checked against a queue-based frame model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fir_frame_buffer;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_frame_buffer_if #(.DW(DW), .N(N), .CW(CW)) bus ();

  fir_frame_buffer #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [N*DW-1:0] f, input int k);
    return f[k*DW +: DW];
  endfunction

  // Model: a partial frame being collected plus a FIFO of at most two complete frames
  logic [DW-1:0]   part   [$];
  logic [N*DW-1:0] frames [$];
  logic [CW-1:0]   m_cnt;
  logic            m_ovf;
  bit              started = 0;

  always @(posedge clk) begin
    int sz;
    logic [N*DW-1:0] f;
    started = 1;
    if (rst) begin
      part.delete();
      frames.delete();
      m_cnt = '0;
      m_ovf = 1'b0;
    end else begin
      sz = frames.size();
      if (sz > 0 && bus.frame_ready) begin
        void'(frames.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (bus.fir_valid) begin
        if (sz == 2) begin
          m_ovf = 1'b1;
        end else begin
          part.push_back(bus.fir_d);
          if (part.size() == N) begin
            for (int k = 0; k < N; k++) f[k*DW +: DW] = part[k];
            frames.push_back(f);
            part.delete();
          end
        end
      end
    end
  end

  int          pulses   = 0;
  bit          saw_wrap = 0;
  logic [CW-1:0] prev_cnt = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("frame_valid", bus.frame_valid, frames.size() > 0);
      chk("frame_cnt",   bus.frame_cnt,   m_cnt);
      chk("overflow",    bus.overflow,    m_ovf);
      if (frames.size() > 0) chk("frame_data", bus.frame_data, frames[0]);
      if (bus.frame_valid === 1'b1) pulses++;
      if (prev_cnt == 8'hFF && bus.frame_cnt == 8'h00) saw_wrap = 1;
      prev_cnt = bus.frame_cnt;
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    bus.fir_valid   = v;
    bus.fir_d       = d;
    bus.frame_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.frame_valid, 1'b0);
    chk("rst_ovf",   bus.overflow,    1'b0);
    chk("rst_cnt",   bus.frame_cnt,   8'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] exp_f;
    int base;

    rst             = 1'b1;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
    @(negedge clk);
    chk("reset_valid", bus.frame_valid, 1'b0);
    chk("reset_data",  bus.frame_data,  256'd0);
    chk("reset_cnt",   bus.frame_cnt,   8'd0);
    chk("reset_ovf",   bus.overflow,    1'b0);
    rst = 1'b0;

    // First frame held with frame_ready low
    for (int i = 1; i <= 16; i++) drive(1'b1, DW'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("t1_valid", bus.frame_valid, 1'b1);
    chk("t1_w0",    word(bus.frame_data, 0),  16'h0001);
    chk("t1_w15",   word(bus.frame_data, 15), 16'h0010);
    chk("t1_cnt",   bus.frame_cnt, 8'd0);
    chk("t1_ovf",   bus.overflow,  1'b0);

    // Second bank fills, then two back-to-back handoffs
    for (int i = 17; i <= 32; i++) drive(1'b1, DW'(i), 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("t2_a_w0",  word(bus.frame_data, 0), 16'h0001);
    drive(1'b0, '0, 1'b1);
    chk("t2_b_w0",  word(bus.frame_data, 0),  16'h0011);
    chk("t2_b_w15", word(bus.frame_data, 15), 16'h0020);
    chk("t2_b_cnt", bus.frame_cnt, 8'd1);
    drive(1'b0, '0, 1'b0);
    chk("t2_valid", bus.frame_valid, 1'b0);
    chk("t2_cnt",   bus.frame_cnt,   8'd2);

    // Both banks full, overflow drops, including at the acceptance edge
    for (int i = 'h21; i <= 'h40; i++) drive(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h7FFF, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("t3_ovf", bus.overflow, 1'b1);
    chk("t3_w0",  word(bus.frame_data, 0), 16'h0021);
    drive(1'b1, 16'h7FFF, 1'b1);
    for (int i = 'h41; i <= 'h50; i++) drive(1'b1, DW'(i), 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t3_new_valid", bus.frame_valid, 1'b1);
    chk("t3_new_w0",    word(bus.frame_data, 0),  16'h0041);
    chk("t3_new_w15",   word(bus.frame_data, 15), 16'h0050);
    chk("t3_cnt",       bus.frame_cnt, 8'd4);
    chk("t3_ovf_stick", bus.overflow,  1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t3_cnt_end", bus.frame_cnt, 8'd5);

    // Gapped input with signed samples
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, DW'(k - 8), 1'b1);
      drive(1'b0, '0, 1'b1);
      if (k == 15) begin
        chk("t4_valid", bus.frame_valid, 1'b1);
        chk("t4_w0",    word(bus.frame_data, 0),  16'hFFF8);
        chk("t4_w8",    word(bus.frame_data, 8),  16'h0000);
        chk("t4_w15",   word(bus.frame_data, 15), 16'h0007);
      end
    end
    drive(1'b0, '0, 1'b0);
    chk("t4_done", bus.frame_valid, 1'b0);
    chk("t4_cnt",  bus.frame_cnt,   8'd1);
    chk("t4_ovf",  bus.overflow,    1'b0);

    // Reset mid-frame discards the partial frame
    do_reset();
    for (int k = 0; k < 9; k++) drive(1'b1, DW'('h200 + k), 1'b0);
    do_reset();
    for (int k = 0; k < 16; k++) drive(1'b1, DW'('h100 + k), 1'b0);
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) exp_f[k*DW +: DW] = DW'('h100 + k);
    chk("t5_valid", bus.frame_valid, 1'b1);
    chk("t5_frame", bus.frame_data,  exp_f);
    chk("t5_cnt",   bus.frame_cnt,   8'd0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t5_cnt_after", bus.frame_cnt, 8'd1);

    // Continuous streaming, 300 frames, counter wrap
    do_reset();
    saw_wrap = 0;
    base = pulses;
    for (int i = 0; i < 300 * N; i++) drive(1'b1, DW'(i), 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t6_pulses", pulses - base, 300);
    chk("t6_cnt",    bus.frame_cnt, 8'd44);
    chk("t6_ovf",    bus.overflow,  1'b0);
    chk("t6_wrap",   saw_wrap,      1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
